// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: HUNT/LOCK framing FSM steering a serial sample stream to four
// registered channel outputs. Define TDM_DEMUX4_FRAME_LATCH_EN to deliver whole frames at once.
module tdm_demux4 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [3:0]       out_valid,
   output logic             frame_done,
   output logic             sync_err,
   output logic             locked
);

   typedef enum logic {StHunt, StLock} state_e;

   state_e                state_q, state_d;
   logic [1:0]            slot_q, slot_d;
   logic [3:0][WIDTH-1:0] data_q, data_d;
   logic [3:0]            vld_q, vld_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  take;
   logic [1:0]            take_slot;

   // Framing decisions: which slot (if any) the current sample belongs to.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      err_d     = 1'b0;
      take      = 1'b0;
      take_slot = 2'd0;
      if (din_valid) begin
         if (frame_sync) begin
            take      = 1'b1;
            take_slot = 2'd0;
            state_d   = StLock;
            slot_d    = 2'd1;
            err_d     = (state_q == StLock) && (slot_q != 2'd0);
         end else if (state_q == StLock) begin
            if (slot_q == 2'd0) begin
               err_d   = 1'b1;
               state_d = StHunt;
            end else begin
               take      = 1'b1;
               take_slot = slot_q;
               slot_d    = slot_q + 2'd1;
            end
         end
      end
   end

`ifdef TDM_DEMUX4_FRAME_LATCH_EN
   logic [2:0][WIDTH-1:0] shadow_q, shadow_d;

   // Slots 0-2 wait in shadow registers; slot 3 releases the whole frame.
   always_comb begin
      shadow_d = shadow_q;
      data_d   = data_q;
      vld_d    = 4'b0000;
      done_d   = 1'b0;
      if (take) begin
         if (take_slot == 2'd3) begin
            data_d = {din, shadow_q};
            vld_d  = 4'b1111;
            done_d = 1'b1;
         end else begin
            shadow_d[take_slot] = din;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`else
   always_comb begin
      data_d = data_q;
      vld_d  = 4'b0000;
      done_d = 1'b0;
      if (take) begin
         data_d[take_slot] = din;
         vld_d[take_slot]  = 1'b1;
         done_d            = (take_slot == 2'd3);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StHunt;
         slot_q  <= 2'd0;
         data_q  <= '0;
         vld_q   <= 4'b0000;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign out0       = data_q[0];
   assign out1       = data_q[1];
   assign out2       = data_q[2];
   assign out3       = data_q[3];
   assign out_valid  = vld_q;
   assign frame_done = done_q;
   assign sync_err   = err_q;
   assign locked     = (state_q == StLock);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: slot-position model checked every cycle plus directed
// literal expectations. Covers both builds (TDM_DEMUX4_FRAME_LATCH_EN defined or not).
module tb_tdm_demux4;

`ifdef TDM_DEMUX4_FRAME_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       frame_sync = 1'b0;
   logic [7:0] out0, out1, out2, out3;
   logic [3:0] out_valid;
   logic       frame_done, sync_err, locked;

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Model: pos = -1 while hunting, else the slot number the next sample should carry.
   int         pos = -1;
   logic [7:0] m_out [4] = '{default: 8'h00};
   logic [7:0] m_sh  [4] = '{default: 8'h00};
   logic [3:0] m_vld = 4'b0000;
   logic       m_done = 1'b0;
   logic       m_err = 1'b0;
   logic       m_lock = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos    = -1;
      m_vld  = 4'b0000;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_lock = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_out[i] = 8'h00;
         m_sh[i]  = 8'h00;
      end
   endtask

   task automatic model_accept(input int k, input logic [7:0] d);
      if (LATCH) begin
         m_sh[k] = d;
         if (k == 3) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
            m_vld = 4'b1111;
         end
      end else begin
         m_out[k] = d;
         m_vld[k] = 1'b1;
      end
      if (k == 3) m_done = 1'b1;
   endtask

   task automatic model_step();
      m_vld  = 4'b0000;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (din_valid) begin
            if (frame_sync) begin
               m_err = (pos > 0);
               model_accept(0, din);
               pos = 1;
            end else if (pos == 0) begin
               m_err = 1'b1;
               pos   = -1;
            end else if (pos > 0) begin
               model_accept(pos, din);
               pos = (pos + 1) % 4;
            end
         end
         m_lock = (pos >= 0);
      end
   endtask

   // One clock cycle: inputs driven at the falling edge, model advanced at the rising edge.
   task automatic step(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      din_valid  = v;
      frame_sync = s;
      din        = d;
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out0", out0, m_out[0]);
         chk("out1", out1, m_out[1]);
         chk("out2", out2, m_out[2]);
         chk("out3", out3, m_out[3]);
         chk("out_valid", out_valid, m_vld);
         chk("frame_done", frame_done, m_done);
         chk("sync_err", sync_err, m_err);
         chk("locked", locked, m_lock);
         chk("vld_shape",
             ($countones(out_valid) <= 1) || (LATCH && out_valid == 4'b1111), 1);
      end
   end

   initial begin
      #3;
      rst_n = 1'b0;
      model_reset();
      chk_en = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      chk("rst_out0", out0, 8'h00);
      chk("rst_vld", out_valid, 4'b0000);
      chk("rst_locked", locked, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame A0..A3
      step(1'b1, 1'b1, 8'hA0);
      chk("s1_first_out0", out0, LATCH ? 8'h00 : 8'hA0);
      chk("s1_first_vld", out_valid, LATCH ? 4'b0000 : 4'b0001);
      step(1'b1, 1'b0, 8'hA1);
      step(1'b1, 1'b0, 8'hA2);
      step(1'b1, 1'b0, 8'hA3);
      chk("s1_vld", out_valid, LATCH ? 4'b1111 : 4'b1000);
      chk("s1_done", frame_done, 1'b1);
      chk("s1_out0", out0, 8'hA0);
      chk("s1_out1", out1, 8'hA1);
      chk("s1_out2", out2, 8'hA2);
      chk("s1_out3", out3, 8'hA3);
      chk("s1_locked", locked, 1'b1);

      // Missing sync after a complete frame
      step(1'b1, 1'b0, 8'h55);
      chk("s2_err", sync_err, 1'b1);
      chk("s2_locked", locked, 1'b0);
      chk("s2_out0", out0, 8'hA0);
      step(1'b0, 1'b0, 8'h00);
      chk("s2_err_pulse", sync_err, 1'b0);

      // Unsynced samples while hunting are dropped
      step(1'b1, 1'b0, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      chk("s3_drop_vld", out_valid, 4'b0000);
      step(1'b1, 1'b1, 8'h33);
      chk("s3_err", sync_err, 1'b0);
      chk("s3_out0", out0, LATCH ? 8'hA0 : 8'h33);
      chk("s3_vld", out_valid, LATCH ? 4'b0000 : 4'b0001);

      // Early sync at slot 2 resynchronises
      step(1'b1, 1'b0, 8'h44);
      step(1'b1, 1'b1, 8'h77);
      chk("s4_err", sync_err, 1'b1);
      chk("s4_done", frame_done, 1'b0);
      chk("s4_out0", out0, LATCH ? 8'hA0 : 8'h77);
      step(1'b1, 1'b0, 8'h88);
      chk("s4_out1", out1, LATCH ? 8'hA1 : 8'h88);
      chk("s4_vld", out_valid, LATCH ? 4'b0000 : 4'b0010);
      step(1'b1, 1'b0, 8'h99);
      step(1'b1, 1'b0, 8'hAA);
      chk("s4_frame_out0", out0, 8'h77);
      chk("s4_frame_done", frame_done, 1'b1);

      // Frame with idle gaps; sync exactly at expected slot 0
      step(1'b1, 1'b1, 8'hB0);
      chk("s5_no_err", sync_err, 1'b0);
      for (int k = 1; k < 4; k++) begin
         repeat (3) step(1'b0, 1'b0, 8'hEE);
         step(1'b1, 1'b0, 8'hB0 + 8'(k));
      end
      chk("s5_out3", out3, 8'hB3);
      chk("s5_done", frame_done, 1'b1);

      // Sync on slot 3: partial frame never completes
      step(1'b1, 1'b1, 8'hC0);
      step(1'b1, 1'b0, 8'hC1);
      step(1'b1, 1'b0, 8'hC2);
      step(1'b1, 1'b1, 8'hC3);
      chk("s6_err", sync_err, 1'b1);
      chk("s6_done", frame_done, 1'b0);
      step(1'b1, 1'b0, 8'hD1);
      step(1'b1, 1'b0, 8'hD2);
      step(1'b1, 1'b0, 8'hD3);
      chk("s6_out0", out0, 8'hC3);

      // Reset mid-frame
      step(1'b1, 1'b1, 8'hE0);
      step(1'b1, 1'b0, 8'hE1);
      @(negedge clk);
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("s7_out0", out0, 8'h00);
      chk("s7_out1", out1, 8'h00);
      chk("s7_vld", out_valid, 4'b0000);
      chk("s7_locked", locked, 1'b0);
      model_reset();
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'hF1);
      step(1'b1, 1'b0, 8'hF2);
      chk("s7_hunt_vld", out_valid, 4'b0000);
      chk("s7_hunt_locked", locked, 1'b0);
      step(1'b1, 1'b1, 8'hF0);
      chk("s7_relock", locked, 1'b1);
      step(1'b0, 1'b0, 8'h00);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of each data sample and each channel output.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: din  input  WIDTH  serial TDM sample stream.
REQ-006 Port: din_valid  input  1  din carries a sample this cycle.
REQ-007 Port: frame_sync  input  1  qualifies the current valid sample as slot 0; ignored when din_valid=0.
REQ-008 Port: out0, out1, out2, out3  output  WIDTH each  registered channel data for slots 0-3.
REQ-009 Port: out_valid  output  4  one-cycle strobe per channel; bit k=1 means outk updated this cycle.
REQ-010 Port: frame_done  output  1  one-cycle pulse when a complete 4-slot frame has been delivered.
REQ-011 Port: sync_err  output  1  one-cycle pulse on a framing violation.
REQ-012 Port: locked  output  1  high while the FSM is in LOCK.

Function
REQ-013 The FSM SHALL have two states: HUNT (reset state) and LOCK. A 2-bit slot counter gives the expected slot.
REQ-014 In HUNT, valid samples without frame_sync SHALL be discarded with no output change.
REQ-015 A valid sample with frame_sync in either state SHALL be taken as slot 0. It SHALL set the FSM to LOCK and set the next slot to 1.
REQ-016 In LOCK, a valid sample without frame_sync SHALL be taken as the current slot, and the slot counter SHALL then increment.
REQ-017 Latency SHALL be exactly 1 cycle: a sample accepted at edge N appears on outk with out_valid[k]=1 in the cycle after edge N.
REQ-018 Outputs and the slot counter SHALL hold their values on cycles with din_valid=0, with no timeout.
REQ-019 Accepting slot 3 SHALL pulse frame_done in the same cycle as out_valid[3]. The slot counter SHALL then wrap to 0, expecting sync.
REQ-020 In LOCK, with expected slot 0, a valid sample without frame_sync SHALL pulse sync_err, discard the sample and move the FSM to HUNT.
REQ-021 In LOCK, frame_sync arriving at slot 1, 2 or 3 SHALL pulse sync_err and resynchronise: that sample is slot 0, and frame_done does not pulse for the partial frame.
REQ-022 frame_sync arriving exactly at expected slot 0 SHALL NOT pulse sync_err.
REQ-023 At most one out_valid bit SHALL be high in any cycle.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force: FSM to HUNT, slot to 0, out0-out3 to 0, out_valid to 4'b0000, frame_done, sync_err and locked to 0.
REQ-025 Asserting reset mid-frame SHALL discard the partial frame. After release, the first valid sample with frame_sync is required to relock.
REQ-026 Deassertion of rst_n SHALL be sampled by clk. No sample is accepted on the edge coincident with release.

Configuration
REQ-027 Macro TDM_DEMUX4_FRAME_LATCH_EN, when defined: samples SHALL go to internal shadow registers.
- out0-out3 SHALL all update together in the frame_done cycle.
- out_valid SHALL be 4'b1111 in that cycle and 0 otherwise.
- A partial frame SHALL never reach the outputs.
REQ-028 Macro TDM_DEMUX4_FRAME_LATCH_EN, when not defined: each outk SHALL update individually as in REQ-017, with no shadow registers.

Verification
REQ-029 Scenario: reset, then valid samples 8'hA0 (with sync), 8'hA1, 8'hA2, 8'hA3 on consecutive cycles -> out0..out3 = A0..A3, out_valid one-hot 0001, 0010, 0100, 1000, frame_done with the last one, locked=1.
REQ-030 Scenario: samples 8'h11, 8'h22 sent without sync while in HUNT, then 8'h33 with sync -> only out0=8'h33 and out_valid=0001; no sync_err.
REQ-031 Scenario: complete frame, then next valid sample 8'h55 without sync -> sync_err pulse, locked=0, out0 unchanged.
REQ-032 Scenario: frame_sync on slot 2 with 8'h77 -> sync_err pulse, out0=8'h77, no frame_done, next sample lands in out1.
REQ-033 Scenario: din_valid gaps of 3 idle cycles between the slots of one frame -> same outputs as REQ-029; outputs stable during the gaps.
REQ-034 Scenario: rst_n pulled low after slot 1 -> all outputs 0 immediately; resuming samples without sync are discarded until sync. With TDM_DEMUX4_FRAME_LATCH_EN defined, rerun REQ-029 -> a single out_valid=1111 cycle.
